sram_dp_arbiter: RTL and testbench
==================================

Name: sram_dp_arbiter

Overview:
- Shares one dual-port synchronous SRAM (one write port, one read port, DATA_WIDTH x DEPTH) between two requesters, A and B.
- Sequences a post-reset zero-fill of the whole array.
- Round-robin arbitrates each SRAM port independently.
- Resolves same-cycle write/read collisions on one address so the read always returns the new data.
- Sits directly in front of the SRAM; requesters never drive the SRAM themselves.

Parameters:
- DATA_WIDTH, 8, word width.
- ADDR_WIDTH, 4, address width.
- DEPTH, 16, words in the SRAM; must equal 2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- a_req / b_req  in  1  request valid; held until the matching gnt.
- a_we / b_we  in  1  1 = write, 0 = read.
- a_addr / b_addr  in  ADDR_WIDTH  word address.
- a_wdata / b_wdata  in  DATA_WIDTH  write data.
- a_gnt / b_gnt  out  1  request accepted this cycle (combinational).
- a_rvalid / b_rvalid  out  1  read data valid (registered).
- a_rdata / b_rdata  out  DATA_WIDTH  read data.
- sram_wr_en, sram_rd_en  out  1  SRAM port strobes.
- sram_wr_addr, sram_rd_addr  out  ADDR_WIDTH.
- sram_data_in  out  DATA_WIDTH.
- sram_data_out  in  DATA_WIDTH  SRAM read data, valid the cycle after sram_rd_en is sampled.
- init_done  out  1  zero-fill complete.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to INIT; init counter = 0.
  - Write and read RR pointers point to A; defer flag = 0.
  - All outputs 0, including gnt, rvalid, rdata and SRAM strobes.
- FSM INIT:
  - Each cycle: sram_wr_en = 1, sram_wr_addr = counter, sram_data_in = 0; counter increments.
  - After the write to DEPTH-1, go to RUN and set init_done = 1. INIT lasts exactly DEPTH cycles.
  - Both gnt are forced 0 during INIT; requests stay pending.
- FSM RUN:
  - Write port candidates: requesters with req & we. Read port candidates: requesters with req & ~we.
  - Per port, one candidate is granted. If both are candidates, the one the port's RR pointer points to is granted.
  - After any grant on a port, that port's pointer moves to the other requester.
  - A write and a read from different requesters may both be granted in the same cycle (both ports used).
  - The gnt cycle is the cycle the SRAM strobe/address/data are driven combinationally from the granted request.
- Read latency:
  - Granted read at cycle T -> rvalid for that requester at T+1, rdata = sram_data_out.
  - rvalid is a one-cycle pulse; rdata holds its last value otherwise.
- Collision (write grant and read grant target the same address in the same cycle):
  - The write is granted; the read is not granted and the defer flag is set.
  - Next cycle the deferred read gets the read port unconditionally.
  - In that cycle, any write to the same address is blocked (no gnt) so the reader sees exactly one write's data.
  - The defer flag clears when the deferred read is granted.
- Same requester never holds two operations at once; one req per requester per cycle.
- rst asserted mid-operation: pending responses are dropped and INIT re-runs in full.

Optional Feature:
- Macro: SRAM_DP_ARBITER_WRITE_FORWARD_EN.
- Defined:
  - On collision, both write and read are granted in the same cycle; the defer flag is unused.
  - The write data is registered, and at T+1 the reader gets rvalid with rdata = forwarded write data instead of sram_data_out.
- Undefined: defer behaviour as above; one extra cycle of read latency on collision.

Decomposition:
- Shared package sram_pkg:
  - FSM state typedef (INIT, RUN).
  - Requester-id encoding (REQ_A = 0, REQ_B = 1).
  - Default width constants.
- Sub-module rr_arb2: 2-way round-robin arbiter with a registered pointer.
  - Instantiated twice, once for the write port and once for the read port.
- FSM, collision logic and response pipeline live in the top module.

Test Plan:
- Release rst -> sram_wr_en high 16 consecutive cycles, addr 0..15, data 8'h00; init_done rises after. A reads addr 4'h5 -> a_rvalid next cycle, a_rdata = 8'h00.
- A writes 8'hAB @ 4'hB, then A reads 4'hB -> a_gnt each op; a_rvalid one cycle after the read gnt; a_rdata = 8'hAB.
- A and B both hold writes (A: 8'h11 @ 3, B: 8'h22 @ 4) for 4 cycles -> grants alternate A, B, A, B starting with A; final mem[3] = 8'h11, mem[4] = 8'h22.
- A writes 8'hFF @ 4'hB while B reads 4'hB in the same cycle:
  - Without macro: a_gnt at T, b_gnt at T+1, b_rvalid at T+2 with 8'hFF.
  - With macro: both gnt at T, b_rvalid at T+1 with 8'hFF.
- A writes 8'hBB @ 9 while B reads 4'hB in the same cycle -> both gnt at T; b_rvalid at T+1 with the prior mem[11] value.
- Assert rst while A's read is granted -> a_rvalid stays 0, all outputs 0; after release, a full 16-cycle INIT re-runs before any gnt.

Source files
------------

// File: rtl/sram_dp_arbiter_pkg.sv
// Shared types for the dual-port SRAM arbiter: FSM states, requester ids, default widths.
package sram_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ADDR_WIDTH_DEF = 4;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

endpackage

// File: rtl/sram_dp_arbiter_if.sv
// Requester A/B handshake plus SRAM port bundle; master = requesters and SRAM, slave = arbiter.
interface sram_dp_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  a_req, a_we, a_gnt, a_rvalid;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [DATA_WIDTH-1:0] a_wdata, a_rdata;
   logic                  b_req, b_we, b_gnt, b_rvalid;
   logic [ADDR_WIDTH-1:0] b_addr;
   logic [DATA_WIDTH-1:0] b_wdata, b_rdata;
   logic                  sram_wr_en, sram_rd_en;
   logic [ADDR_WIDTH-1:0] sram_wr_addr, sram_rd_addr;
   logic [DATA_WIDTH-1:0] sram_data_in, sram_data_out;
   logic                  init_done;

   modport master (
      output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, sram_data_out,
      input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
      input  sram_wr_en, sram_rd_en, sram_wr_addr, sram_rd_addr, sram_data_in, init_done
   );

   modport slave (
      input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, sram_data_out,
      output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
      output sram_wr_en, sram_rd_en, sram_wr_addr, sram_rd_addr, sram_data_in, init_done
   );
endinterface

// File: rtl/sram_dp_arbiter_rr_arb2.sv
// Two-way round-robin pick with registered pointer; pointer flips to the loser only when
// the caller actually takes the pick (i_take), so vetoed picks keep their priority.
module rr_arb2
   import sram_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_take,
   output logic [1:0] o_pick
);
   req_id_t r_ptr;

   always_comb begin
      o_pick = i_req;
      if (i_req == 2'b11) o_pick = (r_ptr == REQ_A) ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        r_ptr <= REQ_A;
      else if (i_take) r_ptr <= o_pick[0] ? REQ_B : REQ_A;
   end
endmodule

// File: rtl/sram_dp_arbiter.sv
// Zero-fills the SRAM after reset, then round-robins A/B onto its write and read ports.
// Same-address write/read collisions defer the read a cycle, or forward under SRAM_DP_ARBITER_WRITE_FORWARD_EN.
module sram_dp_arbiter
   import sram_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DEPTH      = 16
) (
   input  logic             clk,
   input  logic             rst,
   sram_dp_arbiter_if.slave bus
);
   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_init_cnt;
   logic [1:0]            w_wr_cand, w_rd_cand, w_rd_mask, w_wr_pick, w_rd_pick, r_rvalid;
   logic                  w_run, w_wr_take, w_rd_take, w_same;
   logic [ADDR_WIDTH-1:0] w_wr_addr, w_rd_addr;
   logic [DATA_WIDTH-1:0] w_wdata, w_rsp_data, r_a_hold, r_b_hold;
`ifdef SRAM_DP_ARBITER_WRITE_FORWARD_EN
   logic                  w_fwd, r_fwd;
   logic [DATA_WIDTH-1:0] r_fwd_data;
`else
   logic                  w_defer_set, r_defer;
   req_id_t               r_defer_id;
`endif

   assign w_run = (r_state == ST_RUN);
`ifdef SRAM_DP_ARBITER_WRITE_FORWARD_EN
   assign w_rd_mask = 2'b11;
`else
   // A deferred read owns the read port outright on the following cycle
   assign w_rd_mask = !r_defer ? 2'b11 : ((r_defer_id == REQ_B) ? 2'b10 : 2'b01);
`endif
   assign w_wr_cand = {2{w_run}} & {bus.b_req & bus.b_we, bus.a_req & bus.a_we};
   assign w_rd_cand = {2{w_run}} & w_rd_mask & {bus.b_req & ~bus.b_we, bus.a_req & ~bus.a_we};

   rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .i_req(w_wr_cand), .i_take(w_wr_take), .o_pick(w_wr_pick));
   rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .i_req(w_rd_cand), .i_take(w_rd_take), .o_pick(w_rd_pick));

   assign w_wr_addr = w_wr_pick[1] ? bus.b_addr  : bus.a_addr;
   assign w_wdata   = w_wr_pick[1] ? bus.b_wdata : bus.a_wdata;
   assign w_rd_addr = w_rd_pick[1] ? bus.b_addr  : bus.a_addr;
   assign w_same    = (|w_wr_pick) & (|w_rd_pick) & (w_wr_addr == w_rd_addr);

   always_comb begin
      w_state_nxt      = r_state;
      w_wr_take        = 1'b0;
      w_rd_take        = 1'b0;
`ifdef SRAM_DP_ARBITER_WRITE_FORWARD_EN
      w_fwd            = 1'b0;
`else
      w_defer_set      = 1'b0;
`endif
      bus.sram_wr_en   = 1'b0;
      bus.sram_wr_addr = '0;
      bus.sram_data_in = '0;
      bus.sram_rd_en   = 1'b0;
      bus.sram_rd_addr = '0;
      bus.a_gnt        = 1'b0;
      bus.b_gnt        = 1'b0;
      case (r_state)
         ST_INIT: begin
            // Gated by rst so the strobe is low while reset is held
            bus.sram_wr_en   = rst;
            bus.sram_wr_addr = r_init_cnt;
            if (r_init_cnt == ADDR_WIDTH'(DEPTH - 1)) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
`ifdef SRAM_DP_ARBITER_WRITE_FORWARD_EN
            w_wr_take = |w_wr_pick;
            w_rd_take = |w_rd_pick;
            w_fwd     = w_same;
`else
            w_wr_take   = (|w_wr_pick) & ~(r_defer & w_same);
            w_rd_take   = (|w_rd_pick) & ~(~r_defer & w_same);
            w_defer_set = ~r_defer & w_same;
`endif
            bus.sram_wr_en   = w_wr_take;
            bus.sram_wr_addr = w_wr_take ? w_wr_addr : '0;
            bus.sram_data_in = w_wr_take ? w_wdata : '0;
            bus.sram_rd_en   = w_rd_take;
            bus.sram_rd_addr = w_rd_take ? w_rd_addr : '0;
            bus.a_gnt        = (w_wr_take & w_wr_pick[0]) | (w_rd_take & w_rd_pick[0]);
            bus.b_gnt        = (w_wr_take & w_wr_pick[1]) | (w_rd_take & w_rd_pick[1]);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_INIT;
         r_init_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rvalid <= '0;
         r_a_hold <= '0;
         r_b_hold <= '0;
      end else begin
         r_rvalid <= {w_rd_take & w_rd_pick[1], w_rd_take & w_rd_pick[0]};
         if (r_rvalid[0]) r_a_hold <= w_rsp_data;
         if (r_rvalid[1]) r_b_hold <= w_rsp_data;
      end
   end

`ifdef SRAM_DP_ARBITER_WRITE_FORWARD_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fwd      <= 1'b0;
         r_fwd_data <= '0;
      end else begin
         r_fwd <= w_fwd;
         if (w_fwd) r_fwd_data <= w_wdata;
      end
   end
   assign w_rsp_data = r_fwd ? r_fwd_data : bus.sram_data_out;
`else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_defer    <= 1'b0;
         r_defer_id <= REQ_A;
      end else if (w_defer_set) begin
         r_defer    <= 1'b1;
         r_defer_id <= w_rd_pick[1] ? REQ_B : REQ_A;
      end else if (r_defer & w_rd_take) begin
         r_defer <= 1'b0;
      end
   end
   assign w_rsp_data = bus.sram_data_out;
`endif

   assign bus.a_rvalid  = r_rvalid[0];
   assign bus.b_rvalid  = r_rvalid[1];
   assign bus.a_rdata   = r_rvalid[0] ? w_rsp_data : r_a_hold;
   assign bus.b_rdata   = r_rvalid[1] ? w_rsp_data : r_b_hold;
   assign bus.init_done = w_run;
endmodule

// File: tb/tb_sram_dp_arbiter.sv
// Randomised + directed bench for sram_dp_arbiter: SRAM model, per-cycle reference model of
// the arbitration rules, and per-requester read-data scoreboard queues.
module tb_sram_dp_arbiter;
   import sram_pkg::*;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sram_dp_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
   sram_dp_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   logic [DW-1:0] sram_mem [DEPTH];
   always @(posedge clk) begin
      if (bus.sram_wr_en) sram_mem[bus.sram_wr_addr] <= bus.sram_data_in;
      if (bus.sram_rd_en) bus.sram_data_out <= sram_mem[bus.sram_rd_addr];
   end

   logic          req [2];
   logic          we [2];
   logic [AW-1:0] addr [2];
   logic [DW-1:0] wdata [2];
   logic          hold [2];
   logic          gnt_seen [2];
   assign bus.a_req = req[0];  assign bus.a_we = we[0];
   assign bus.a_addr = addr[0]; assign bus.a_wdata = wdata[0];
   assign bus.b_req = req[1];  assign bus.b_we = we[1];
   assign bus.b_addr = addr[1]; assign bus.b_wdata = wdata[1];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model state
   logic [DW-1:0] ref_mem [DEPTH];
   int            ref_wr_last, ref_rd_last, ref_def_id, phase;
   bit            ref_def_vld;
   bit            ref_rv [2];
   logic [DW-1:0] ref_hold [2];
   logic [DW-1:0] exp_q0 [$];
   logic [DW-1:0] exp_q1 [$];

   function automatic int pick(input bit c0, input bit c1, input int last);
      if (c0 && c1) return (last == 0) ? 1 : 0;
      if (c0) return 0;
      if (c1) return 1;
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      ref_wr_last = 1;
      ref_rd_last = 1;
      ref_def_vld = 0;
      ref_def_id  = 0;
      for (int r = 0; r < 2; r++) begin
         ref_rv[r]   = 0;
         ref_hold[r] = '0;
         gnt_seen[r] = 1'b0;
      end
      exp_q0.delete();
      exp_q1.delete();
   endtask

   task automatic run_model();
      bit            wc [2];
      bit            rc [2];
      int            ww, rw, sz;
      bit            same;
      logic          rv [2];
      logic          g [2];
      logic [DW-1:0] rd [2];
      logic [DW-1:0] d;
      rv[0] = bus.a_rvalid; rv[1] = bus.b_rvalid;
      rd[0] = bus.a_rdata;  rd[1] = bus.b_rdata;
      g[0]  = bus.a_gnt;    g[1]  = bus.b_gnt;
      chk("init_done", bus.init_done, 1);
      for (int r = 0; r < 2; r++) begin
         chk($sformatf("rvalid_%0d", r), rv[r], ref_rv[r]);
         if (rv[r]) begin
            sz = (r == 0) ? exp_q0.size() : exp_q1.size();
            chk($sformatf("rsp_pending_%0d", r), sz > 0, 1);
            if (sz > 0) begin
               if (r == 0) d = exp_q0.pop_front();
               else        d = exp_q1.pop_front();
               chk($sformatf("rdata_%0d", r), rd[r], d);
               ref_hold[r] = d;
            end
         end else begin
            chk($sformatf("rdata_hold_%0d", r), rd[r], ref_hold[r]);
         end
      end
      for (int r = 0; r < 2; r++) begin
         wc[r] = req[r] && we[r];
         rc[r] = req[r] && !we[r];
      end
`ifndef SRAM_DP_ARBITER_WRITE_FORWARD_EN
      if (ref_def_vld) rc[1 - ref_def_id] = 0;
`endif
      ww = pick(wc[0], wc[1], ref_wr_last);
      rw = pick(rc[0], rc[1], ref_rd_last);
      same = (ww >= 0) && (rw >= 0) && (addr[ww] == addr[rw]);
`ifndef SRAM_DP_ARBITER_WRITE_FORWARD_EN
      if (ref_def_vld) begin
         if (same) ww = -1;
         ref_def_vld = 0;
      end else if (same) begin
         ref_def_vld = 1;
         ref_def_id  = rw;
         rw          = -1;
      end
`endif
      for (int r = 0; r < 2; r++) begin
         chk($sformatf("gnt_%0d", r), g[r], (ww == r) || (rw == r));
         gnt_seen[r] = g[r];
      end
      chk("sram_wr_en", bus.sram_wr_en, ww >= 0);
      chk("sram_rd_en", bus.sram_rd_en, rw >= 0);
      if (ww >= 0) begin
         chk("sram_wr", {bus.sram_wr_addr, bus.sram_data_in}, {addr[ww], wdata[ww]});
         ref_mem[addr[ww]] = wdata[ww];
         ref_wr_last = ww;
      end
      if (rw >= 0) begin
         chk("sram_rd_addr", bus.sram_rd_addr, addr[rw]);
         if (rw == 0) exp_q0.push_back(ref_mem[addr[rw]]);
         else         exp_q1.push_back(ref_mem[addr[rw]]);
         ref_rd_last = rw;
      end
      for (int r = 0; r < 2; r++) ref_rv[r] = (rw == r);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("reset_outputs",
             {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.a_rdata, bus.b_rdata,
              bus.sram_wr_en, bus.sram_rd_en, bus.sram_wr_addr, bus.sram_rd_addr,
              bus.sram_data_in, bus.init_done}, 0);
         model_reset();
         phase = 0;
      end else if (phase < DEPTH) begin
         chk("init_write", {bus.sram_wr_en, bus.sram_wr_addr, bus.sram_data_in},
             {1'b1, AW'(phase), DW'(0)});
         chk("init_quiet", {bus.a_gnt, bus.b_gnt, bus.sram_rd_en, bus.init_done,
                            bus.a_rvalid, bus.b_rvalid}, 0);
         gnt_seen[0] = 1'b0;
         gnt_seen[1] = 1'b0;
         phase++;
      end else begin
         run_model();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++)
         if (req[r] && gnt_seen[r] && !hold[r]) req[r] = 1'b0;
   endtask

   task automatic issue(input int r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] dat);
      req[r] = 1'b1; we[r] = w; addr[r] = a; wdata[r] = dat;
   endtask

   task automatic wait_idle(input int budget, output int n);
      n = 0;
      while ((req[0] || req[1]) && n < budget) begin
         step();
         n++;
      end
      chk("idle_timeout", req[0] || req[1], 0);
      req[0] = 1'b0;
      req[1] = 1'b0;
   endtask

   int n;
   initial begin
      for (int r = 0; r < 2; r++) begin
         req[r] = 1'b0; we[r] = 1'b0; addr[r] = '0; wdata[r] = '0;
         hold[r] = 1'b0; gnt_seen[r] = 1'b0;
      end
      phase = 0;
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      repeat (DEPTH + 2) step();

      // Read of freshly zero-filled word
      issue(0, 1'b0, 4'h5, 8'h00);
      wait_idle(10, n);
      repeat (2) step();

      // Contending writes held for four cycles: A, B, A, B
      hold[0] = 1'b1; hold[1] = 1'b1;
      issue(0, 1'b1, 4'h3, 8'h11);
      issue(1, 1'b1, 4'h4, 8'h22);
      repeat (4) step();
      hold[0] = 1'b0; hold[1] = 1'b0;
      wait_idle(10, n);
      step();
      chk("mem3", sram_mem[3], 8'h11);
      chk("mem4", sram_mem[4], 8'h22);

      // Write then read back
      issue(0, 1'b1, 4'hB, 8'hAB);
      wait_idle(10, n);
      issue(0, 1'b0, 4'hB, 8'h00);
      wait_idle(10, n);
      repeat (2) step();

      // Same-address collision
      issue(0, 1'b1, 4'hB, 8'hFF);
      issue(1, 1'b0, 4'hB, 8'h00);
      wait_idle(10, n);
      repeat (3) step();

      // Different-address write and read in the same cycle
      issue(0, 1'b1, 4'h9, 8'hBB);
      issue(1, 1'b0, 4'hB, 8'h00);
      wait_idle(10, n);
      repeat (3) step();

      // Random traffic on a narrow address range to provoke collisions
      for (int c = 0; c < 400; c++) begin
         for (int r = 0; r < 2; r++)
            if (!req[r] && $urandom_range(0, 2) != 0)
               issue(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom));
         step();
      end
      wait_idle(20, n);
      repeat (2) step();

      // Reset lands during a granted read
      issue(0, 1'b0, 4'h2, 8'h00);
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      issue(1, 1'b1, 4'h1, 8'h77);
      wait_idle(DEPTH + 10, n);
      chk("first_gnt_after_reinit", n, DEPTH + 1);
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
